hci_core_rr_mux: RTL

- Round-robin arbiter sharing one hci_core master port among NB_IN_CHAN hci_core requesters.
- Typically placed upstream of a wide-port splitter, so several streamers share one wide TCDM port.
- Grant-lock keeps a stalled request stable until it is granted; that stability is required by splitting and masking logic downstream.
- An in-order ID FIFO routes each response back to the requester that issued it.

---
 rtl/hci_core_rr_mux_if.sv | 35 +++
 rtl/hci_core_rr_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hci_core_rr_mux_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hci_core_intf: request/response bundle for one hci_core TCDM port.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
interface hci_core_intf #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 2
) ();
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [DW/8-1:0] be;
  logic [15:0]   boffs;
  logic [UW-1:0] user;
  logic          lrdy;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_opc;
  logic [UW-1:0] r_user;

  modport master (
    output req, add, wen, data, be, boffs, user, lrdy,
    input  gnt, r_data, r_valid, r_opc, r_user
  );

  modport slave (
    input  req, add, wen, data, be, boffs, user, lrdy,
    output gnt, r_data, r_valid, r_opc, r_user
  );
endinterface
`default_nettype wire

// File: rtl/hci_core_rr_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hci_core_rr_mux: round-robin, grant-locked N:1 hci_core arbiter with an |
// | in-order ID FIFO steering each response back to its requester.         |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module hci_core_rr_mux #(
  parameter int unsigned NB_IN_CHAN      = 2,
  parameter int unsigned DW              = 64,
  parameter int unsigned AW              = 32,
  parameter int unsigned UW              = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  hci_core_intf.slave                            tcdm_slave [NB_IN_CHAN-1:0],
  hci_core_intf.master                           tcdm_master,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   spurious_rvalid_o
);
  localparam int unsigned IW = $clog2(NB_IN_CHAN);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB_IN_CHAN-1);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(NB_IN_CHAN);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic [NB_IN_CHAN-1:0] req, wen, lrdy, gnt, rvalid;
  logic [AW-1:0]         add   [NB_IN_CHAN];
  logic [DW-1:0]         data  [NB_IN_CHAN];
  logic [DW/8-1:0]       be    [NB_IN_CHAN];
  logic [15:0]           boffs [NB_IN_CHAN];
  logic [UW-1:0]         user  [NB_IN_CHAN];

  logic [IW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, sel, head;
  logic          lock_q, lock_d, found, out_req, hs, full, empty, pop;
  logic [IW:0]   cand;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IW-1:0] fifo_d [MAX_OUTSTANDING];

  for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_chan
    assign req[i]   = tcdm_slave[i].req;
    assign add[i]   = tcdm_slave[i].add;
    assign wen[i]   = tcdm_slave[i].wen;
    assign data[i]  = tcdm_slave[i].data;
    assign be[i]    = tcdm_slave[i].be;
    assign boffs[i] = tcdm_slave[i].boffs;
    assign user[i]  = tcdm_slave[i].user;
    assign lrdy[i]  = tcdm_slave[i].lrdy;
    assign tcdm_slave[i].gnt     = gnt[i];
    assign tcdm_slave[i].r_valid = rvalid[i];
    assign tcdm_slave[i].r_data  = tcdm_master.r_data;
    assign tcdm_slave[i].r_opc   = tcdm_master.r_opc;
    assign tcdm_slave[i].r_user  = tcdm_master.r_user;
  end

  // A locked requester keeps the port; otherwise scan cyclically from rr_q.
  always_comb begin
    sel   = lock_idx_q;
    found = lock_q;
    cand  = '0;
    if (!lock_q) begin
      for (int unsigned k = 0; k < NB_IN_CHAN; k++) begin
        cand = {1'b0, rr_q} + (IW+1)'(k);
        if (cand >= N_EXT) cand = cand - N_EXT;
        if (!found && req[cand[IW-1:0]]) begin
          sel   = cand[IW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign out_req = found & req[sel] & ~full;
  assign hs      = out_req & tcdm_master.gnt;
  assign pop     = tcdm_master.r_valid & ~empty;
  assign head    = fifo_q[rptr_q];

  assign tcdm_master.req   = out_req;
  assign tcdm_master.add   = add[sel];
  assign tcdm_master.wen   = wen[sel];
  assign tcdm_master.data  = data[sel];
  assign tcdm_master.be    = be[sel];
  assign tcdm_master.boffs = boffs[sel];
  assign tcdm_master.user  = user[sel];
  assign tcdm_master.lrdy  = lrdy[sel];

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    if (hs)  gnt[sel]     = 1'b1;
    if (pop) rvalid[head] = 1'b1;
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    fifo_d     = fifo_q;
    if (hs) rr_d = (sel == LAST_IDX) ? '0 : sel + IW'(1);
    if (out_req && !tcdm_master.gnt) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (tcdm_master.gnt) begin
      lock_d = 1'b0;
    end
    if (hs) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
    end
    if (pop) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Entries are only read between push and pop, so they need no reset.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign outstanding_o     = cnt_q;
  assign spurious_rvalid_o = tcdm_master.r_valid & empty;

`ifndef SYNTHESIS
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    lock_q |-> req[lock_idx_q]);
`endif
endmodule
`default_nettype wire
